// File: rtl/hdmi_i2c_write_engine.sv
// Bit-level I2C master that writes one {dev_addr+W, reg, data} word to the ADV7513:
// START, three ACK-checked bytes MSB first, STOP, on open-drain SCL/SDA enables.
module hdmi_i2c_write_engine #(
  parameter int unsigned CLK_DIV = 125
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [23:0] i2c_data,
  output logic        busy,
  output logic        done,
  output logic        ack_ok,
  output logic        scl_oe,
  output logic        sda_oe,
  input  logic        sda_in,
  output logic [2:0]  dbg_state_o
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    BYTE  = 3'd2,
    ACK   = 3'd3,
    STOP  = 3'd4
  } state_t;

  localparam logic [9:0] CNT_MAX = 10'(CLK_DIV - 1);

  state_t      state_q, state_d;
  logic [9:0]  cnt_q, cnt_d;
  logic [1:0]  qtr_q, qtr_d;
  logic [2:0]  bit_q, bit_d;
  logic [1:0]  byte_q, byte_d;
  logic [23:0] sr_q, sr_d;
  logic        nack_q, nack_d;
  logic        ack_pend_q, ack_pend_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        ack_ok_q, ack_ok_d;
  logic        scl_q, scl_d;
  logic        sda_q, sda_d;
  logic        qtr_end, phase_end;

  assign qtr_end   = (cnt_q == CNT_MAX);
  assign phase_end = qtr_end && (qtr_q == 2'd3);

  // Handshake: start is taken only in IDLE (busy=0); busy rises on the next edge and
  // falls on the same edge that raises the one-cycle done pulse; ack_ok is valid from done.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    qtr_d      = qtr_q;
    bit_d      = bit_q;
    byte_d     = byte_q;
    sr_d       = sr_q;
    nack_d     = nack_q;
    ack_pend_d = ack_pend_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    ack_ok_d   = ack_ok_q;

    if (state_q != IDLE) begin
      cnt_d = qtr_end ? 10'd0 : cnt_q + 10'd1;
      if (qtr_end) qtr_d = qtr_q + 2'd1;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = START;
          sr_d       = i2c_data;
          ack_ok_d   = 1'b0;
          busy_d     = 1'b1;
          cnt_d      = 10'd0;
          qtr_d      = 2'd0;
          bit_d      = 3'd0;
          byte_d     = 2'd0;
          nack_d     = 1'b0;
          ack_pend_d = 1'b0;
        end
      end
      START: if (phase_end) state_d = BYTE;
      BYTE: begin
        if (phase_end) begin
          sr_d = {sr_q[22:0], 1'b0};
          if (bit_q == 3'd7) begin
            bit_d   = 3'd0;
            state_d = ACK;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      ACK: begin
        // Sample the slave's answer on the last cycle SCL is high before q3.
        if (qtr_end && qtr_q == 2'd2) nack_d = sda_in;
        if (phase_end) begin
          if (nack_q) begin
            state_d = STOP;
          end else if (byte_q == 2'd2) begin
            state_d    = STOP;
            ack_pend_d = 1'b1;
          end else begin
            byte_d  = byte_q + 2'd1;
            state_d = BYTE;
          end
        end
      end
      STOP: begin
        if (phase_end) begin
          state_d  = IDLE;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          ack_ok_d = ack_pend_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Pad enables are decoded from the next state so they are registered with it.
  always_comb begin
    scl_d = 1'b0;
    sda_d = 1'b0;
    case (state_d)
      START: begin
        scl_d = (qtr_d == 2'd3);
        sda_d = (qtr_d >= 2'd2);
      end
      BYTE: begin
        scl_d = (qtr_d < 2'd2);
        sda_d = ~sr_d[23];
      end
      ACK:  scl_d = (qtr_d < 2'd2);
      STOP: begin
        scl_d = (qtr_d == 2'd0);
        sda_d = (qtr_d < 2'd2);
      end
      default: begin
        scl_d = 1'b0;
        sda_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= 10'd0;
      qtr_q      <= 2'd0;
      bit_q      <= 3'd0;
      byte_q     <= 2'd0;
      sr_q       <= 24'd0;
      nack_q     <= 1'b0;
      ack_pend_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ack_ok_q   <= 1'b0;
      scl_q      <= 1'b0;
      sda_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      qtr_q      <= qtr_d;
      bit_q      <= bit_d;
      byte_q     <= byte_d;
      sr_q       <= sr_d;
      nack_q     <= nack_d;
      ack_pend_q <= ack_pend_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ack_ok_q   <= ack_ok_d;
      scl_q      <= scl_d;
      sda_q      <= sda_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign ack_ok      = ack_ok_q;
  assign scl_oe      = scl_q;
  assign sda_oe      = sda_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_hdmi_i2c_write_engine.sv
// Bench for hdmi_i2c_write_engine: a bus-level slave decodes START/bytes/STOP from the pad
// enables, answers ACK/NACK, and results are compared against a spec-level transaction model.
module tb_hdmi_i2c_write_engine;
  localparam int D = 2;
  localparam int BUDGET = 2000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [23:0] i2c_data = 24'd0;
  logic        busy, done, ack_ok, scl_oe, sda_oe, sda_in;
  logic [2:0]  dbg_state;

  int pass_cnt = 0;
  int total_cnt = 0;

  // slave / bus monitor state
  logic       slave_pull = 1'b0;
  logic       prev_scl = 1'b1;
  logic       prev_sda = 1'b1;
  logic       scl_l, sda_l;
  logic [7:0] shreg = 8'd0;
  int         bit_cnt = 0, byte_cnt = 0, start_cnt = 0, stop_cnt = 0;
  int         nack_at = 3;
  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];

  hdmi_i2c_write_engine #(.CLK_DIV(D)) dut (
    .clk(clk), .reset(reset), .start(start), .i2c_data(i2c_data),
    .busy(busy), .done(done), .ack_ok(ack_ok), .scl_oe(scl_oe), .sda_oe(sda_oe),
    .sda_in(sda_in), .dbg_state_o(dbg_state)
  );

  always #5 clk = ~clk;

  assign sda_in = ~(sda_oe | slave_pull);

  always @(negedge clk) begin
    scl_l = ~scl_oe;
    sda_l = ~(sda_oe | slave_pull);
    if (prev_scl && scl_l && prev_sda && !sda_l) begin
      start_cnt++;
      bit_cnt = 0;
      byte_cnt = 0;
    end else if (prev_scl && scl_l && !prev_sda && sda_l) begin
      stop_cnt++;
    end else if (!prev_scl && scl_l) begin
      bit_cnt++;
      if (bit_cnt <= 8) shreg = {shreg[6:0], sda_l};
      if (bit_cnt == 8) rx_q.push_back(shreg);
      if (bit_cnt == 9) begin
        bit_cnt = 0;
        byte_cnt++;
      end
    end else if (prev_scl && !scl_l) begin
      slave_pull = (bit_cnt == 8) && (byte_cnt != nack_at);
    end
    prev_scl = scl_l;
    prev_sda = ~(sda_oe | slave_pull);
  end

  task automatic clear_mon();
    rx_q.delete();
    exp_q.delete();
    start_cnt = 0;
    stop_cnt = 0;
    bit_cnt = 0;
    byte_cnt = 0;
    slave_pull = 1'b0;
  endtask

  // Reference: bytes on the wire stop after the NACKed byte (nack=3 means all ACKed).
  task automatic model_txn(input logic [23:0] data, input int nack);
    exp_q.push_back(data[23:16]);
    if (nack >= 1) exp_q.push_back(data[15:8]);
    if (nack >= 2) exp_q.push_back(data[7:0]);
  endtask

  function automatic int model_lat(input int nack);
    return (nack >= 3) ? 116 * D : (4 + 36 * (nack + 1) + 4) * D;
  endfunction

  task automatic do_txn(input logic [23:0] data, input int pulse_at, output int lat,
                        output logic b0, output logic a0);
    start = 1'b1;
    i2c_data = data;
    @(posedge clk); #1;
    start = 1'b0;
    b0 = busy;
    a0 = ack_ok;
    lat = 0;
    while (done !== 1'b1 && lat < BUDGET) begin
      @(posedge clk); #1;
      lat++;
      if (pulse_at != 0 && lat == pulse_at) begin
        start = 1'b1;
        i2c_data = 24'h123456;
      end else if (pulse_at != 0 && lat == pulse_at + 1) begin
        start = 1'b0;
        i2c_data = data;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    start = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total_cnt++; if (scl_oe !== 1'b0) $display("FAIL rst_scl: got %b exp 0", scl_oe); else pass_cnt++;
    total_cnt++; if (sda_oe !== 1'b0) $display("FAIL rst_sda: got %b exp 0", sda_oe); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b exp 0", busy); else pass_cnt++;
    total_cnt++; if (done !== 1'b0) $display("FAIL rst_done: got %b exp 0", done); else pass_cnt++;
    total_cnt++; if (ack_ok !== 1'b0) $display("FAIL rst_ack: got %b exp 0", ack_ok); else pass_cnt++;
    total_cnt++; if (dbg_state !== 3'd0) $display("FAIL rst_state: got %0d exp 0", dbg_state); else pass_cnt++;
    reset = 1'b1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    total_cnt++; if ({scl_oe, sda_oe, busy} !== 3'b000) $display("FAIL rst_quiet: got %b exp 000", {scl_oe, sda_oe, busy}); else pass_cnt++;
    total_cnt++; if (start_cnt !== 0) $display("FAIL rst_nostart: got %0d exp 0", start_cnt); else pass_cnt++;
  endtask

  task automatic check_bytes(input string name);
    total_cnt++;
    if (rx_q.size() !== exp_q.size())
      $display("FAIL %s_nbytes: got %0d exp %0d", name, rx_q.size(), exp_q.size());
    else pass_cnt++;
    foreach (exp_q[i]) begin
      if (i < rx_q.size()) begin
        total_cnt++;
        if (rx_q[i] !== exp_q[i]) $display("FAIL %s_byte%0d: got %h exp %h", name, i, rx_q[i], exp_q[i]);
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_full_ack();
    int lat; logic b0, a0;
    clear_mon(); nack_at = 3;
    model_txn(24'h729803, 3);
    do_txn(24'h729803, 0, lat, b0, a0);
    total_cnt++; if (b0 !== 1'b1) $display("FAIL full_busy: got %b exp 1", b0); else pass_cnt++;
    total_cnt++; if (lat !== model_lat(3)) $display("FAIL full_lat: got %0d exp %0d", lat, model_lat(3)); else pass_cnt++;
    total_cnt++; if (ack_ok !== 1'b1) $display("FAIL full_ack: got %b exp 1", ack_ok); else pass_cnt++;
    total_cnt++; if ({busy, scl_oe, sda_oe} !== 3'b000) $display("FAIL full_idle: got %b exp 000", {busy, scl_oe, sda_oe}); else pass_cnt++;
    total_cnt++; if (start_cnt !== 1 || stop_cnt !== 1) $display("FAIL full_cond: got %0d/%0d exp 1/1", start_cnt, stop_cnt); else pass_cnt++;
    check_bytes("full");
    @(posedge clk); #1;
    total_cnt++; if (done !== 1'b0) $display("FAIL full_pulse: got %b exp 0", done); else pass_cnt++;
  endtask

  task automatic test_nack_addr();
    int lat; logic b0, a0;
    clear_mon(); nack_at = 0;
    model_txn(24'h7241FF, 0);
    do_txn(24'h7241FF, 0, lat, b0, a0);
    total_cnt++; if (a0 !== 1'b0) $display("FAIL nack_clr: got %b exp 0", a0); else pass_cnt++;
    total_cnt++; if (lat !== model_lat(0)) $display("FAIL nack_lat: got %0d exp %0d", lat, model_lat(0)); else pass_cnt++;
    total_cnt++; if (ack_ok !== 1'b0) $display("FAIL nack_ack: got %b exp 0", ack_ok); else pass_cnt++;
    total_cnt++; if (stop_cnt !== 1) $display("FAIL nack_stop: got %0d exp 1", stop_cnt); else pass_cnt++;
    check_bytes("nack");
  endtask

  task automatic test_ignore_busy();
    int lat; logic b0, a0;
    clear_mon(); nack_at = 3;
    model_txn(24'h720100, 3);
    do_txn(24'h720100, 90, lat, b0, a0);
    total_cnt++; if (lat !== model_lat(3)) $display("FAIL ign_lat: got %0d exp %0d", lat, model_lat(3)); else pass_cnt++;
    total_cnt++; if (ack_ok !== 1'b1) $display("FAIL ign_ack: got %b exp 1", ack_ok); else pass_cnt++;
    check_bytes("ign");
    repeat (5) @(posedge clk);
    #1;
    total_cnt++; if (busy !== 1'b0) $display("FAIL ign_nolatch: got %b exp 0", busy); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int lat, done_seen; logic b0, a0;
    clear_mon(); nack_at = 3;
    start = 1'b1;
    i2c_data = 24'h729803;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (106) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk); #1;
    total_cnt++; if ({scl_oe, sda_oe, busy, done} !== 4'b0000) $display("FAIL mid_rst: got %b exp 0000", {scl_oe, sda_oe, busy, done}); else pass_cnt++;
    reset = 1'b1;
    done_seen = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (done === 1'b1 || scl_oe === 1'b1 || sda_oe === 1'b1) done_seen++;
    end
    total_cnt++; if (done_seen !== 0) $display("FAIL mid_quiet: got %0d exp 0", done_seen); else pass_cnt++;
    clear_mon(); nack_at = 3;
    model_txn(24'h729803, 3);
    do_txn(24'h729803, 0, lat, b0, a0);
    total_cnt++; if (lat !== model_lat(3)) $display("FAIL mid_lat: got %0d exp %0d", lat, model_lat(3)); else pass_cnt++;
    total_cnt++; if (ack_ok !== 1'b1) $display("FAIL mid_ack: got %b exp 1", ack_ok); else pass_cnt++;
    check_bytes("mid");
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [23:0] d1, d2;
    d1 = 24'($urandom);
    d2 = 24'($urandom);
    clear_mon(); nack_at = 3;
    model_txn(d1, 3);
    model_txn(d2, 3);
    start = 1'b1;
    i2c_data = d1;
    @(posedge clk); #1;
    i2c_data = d2;
    lat = 0;
    while (done !== 1'b1 && lat < BUDGET) begin @(posedge clk); #1; lat++; end
    total_cnt++; if (lat !== model_lat(3)) $display("FAIL b2b_lat1: got %0d exp %0d", lat, model_lat(3)); else pass_cnt++;
    total_cnt++; if (ack_ok !== 1'b1) $display("FAIL b2b_ack1: got %b exp 1", ack_ok); else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++; if (busy !== 1'b1) $display("FAIL b2b_accept: got %b exp 1", busy); else pass_cnt++;
    total_cnt++; if (ack_ok !== 1'b0) $display("FAIL b2b_ackclr: got %b exp 0", ack_ok); else pass_cnt++;
    start = 1'b0;
    lat = 0;
    while (done !== 1'b1 && lat < BUDGET) begin @(posedge clk); #1; lat++; end
    total_cnt++; if (lat !== model_lat(3)) $display("FAIL b2b_lat2: got %0d exp %0d", lat, model_lat(3)); else pass_cnt++;
    total_cnt++; if (ack_ok !== 1'b1) $display("FAIL b2b_ack2: got %b exp 1", ack_ok); else pass_cnt++;
    total_cnt++; if (start_cnt !== 2 || stop_cnt !== 2) $display("FAIL b2b_cond: got %0d/%0d exp 2/2", start_cnt, stop_cnt); else pass_cnt++;
    check_bytes("b2b");
  endtask

  task automatic test_random();
    int lat, nk; logic b0, a0;
    logic [23:0] d;
    for (int it = 0; it < 8; it++) begin
      repeat ($urandom_range(0, 5)) @(posedge clk);
      #1;
      d = 24'($urandom);
      nk = $urandom_range(0, 5);
      if (nk > 3) nk = 3;
      clear_mon(); nack_at = nk;
      model_txn(d, nk);
      do_txn(d, 0, lat, b0, a0);
      total_cnt++; if (lat !== model_lat(nk)) $display("FAIL rnd%0d_lat: got %0d exp %0d", it, lat, model_lat(nk)); else pass_cnt++;
      total_cnt++; if (ack_ok !== (nk == 3)) $display("FAIL rnd%0d_ack: got %b exp %b", it, ack_ok, (nk == 3)); else pass_cnt++;
      total_cnt++; if (stop_cnt !== 1) $display("FAIL rnd%0d_stop: got %0d exp 1", it, stop_cnt); else pass_cnt++;
      check_bytes($sformatf("rnd%0d", it));
    end
  endtask

  initial begin
    test_reset();
    test_full_ack();
    test_nack_addr();
    test_ignore_busy();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
